// File: rtl/branch_ctrl.sv
// EX-stage branch resolution: outcome decode, mispredict redirect, timed front-end flush.
// Optional 2-bit BHT for fetch prediction, enabled by BRANCH_CTRL_BHT_EN.
module branch_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned BHT_ENTRIES  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    output logic        br_un,
    input  logic        br_eq,
    input  logic        br_lt,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        illegal_br,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t             state;
    logic [CNT_W-1:0]   flush_cnt;
    logic               actual_taken;
    logic               illegal;
    logic               resolve;
    logic               mispred;
    logic [31:0]        seq_pc;

    assign br_un = ex_funct3[1];

    // Outcome decode from comparator flags
    always_comb begin
        actual_taken = 1'b0;
        case (ex_funct3)
            3'b000:         actual_taken = br_eq;
            3'b001:         actual_taken = !br_eq;
            3'b100, 3'b110: actual_taken = br_lt;
            3'b101, 3'b111: actual_taken = !br_lt;
            default:        actual_taken = 1'b0;
        endcase
    end

    assign illegal = (ex_funct3[2:1] == 2'b01);
    assign resolve = ex_valid && !ex_stall && (state == S_IDLE);
    assign mispred = resolve && (actual_taken != ex_pred_taken);
    assign seq_pc  = 32'(ex_pc + 32'd4);

    // Resolution / flush sequencer; branches seen while flushing are squashed
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            flush_cnt     <= '0;
            redirect      <= 1'b0;
            redirect_pc   <= '0;
            flush         <= 1'b0;
            illegal_br    <= 1'b0;
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            redirect   <= 1'b0;
            illegal_br <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (resolve) begin
                        br_count   <= br_count + 32'd1;
                        illegal_br <= illegal;
                        if (mispred) begin
                            mispred_count <= mispred_count + 32'd1;
                            redirect      <= 1'b1;
                            redirect_pc   <= actual_taken ? ex_target : seq_pc;
                            flush         <= 1'b1;
                            flush_cnt     <= CNT_W'(FLUSH_CYCLES - 1);
                            state         <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt == '0) begin
                        flush <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef BRANCH_CTRL_BHT_EN
    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             unused_if_pc;

    assign rd_idx        = if_pc[IDX_W+1:2];
    assign wr_idx        = ex_pc[IDX_W+1:2];
    assign if_pred_taken = bht[rd_idx][1];
    assign unused_if_pc  = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    // Saturating 2-bit counters, trained on legal resolutions only
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
        end else if (resolve && !illegal) begin
            if (actual_taken) begin
                if (bht[wr_idx] != 2'b11) bht[wr_idx] <= bht[wr_idx] + 2'd1;
            end else begin
                if (bht[wr_idx] != 2'b00) bht[wr_idx] <= bht[wr_idx] - 2'd1;
            end
        end
    end
`else
    logic unused_if_pc;

    assign if_pred_taken = 1'b0;
    assign unused_if_pc  = ^if_pc;
`endif

endmodule
